// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, FSM states and
// the default watchdog limit.
package axi_lite_pkg;

  localparam int TIMEOUT_DEFAULT = 256;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } master_state_e;

endpackage

// File: rtl/axi_lite_wdog.sv
// Handshake watchdog: cleared on entry to a wait state, counts stalled cycles,
// saturates at TIMEOUT and flags expiry on the last allowed stalled cycle.
module axi_lite_wdog
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic aclk,
  input  logic arst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge aclk) begin
    if (!arst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry fires in the TIMEOUT-th stalled cycle so the valid/ready is held exactly TIMEOUT cycles.
  assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, AW->W->B or AR->R toward
// the slave, then one response (slave code or watchdog timeout) out.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_write,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic [1:0]        o_rsp_resp,
  output logic              o_rsp_timeout,
  output logic              o_awvalid,
  output logic [ADDR_W-1:0] o_awaddr,
  input  logic              i_awready,
  output logic              o_wvalid,
  output logic [DATA_W-1:0] o_wdata,
  input  logic              i_wready,
  input  logic              i_bvalid,
  input  logic [1:0]        i_bresp,
  output logic              o_bready,
  output logic              o_arvalid,
  output logic [ADDR_W-1:0] o_araddr,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  output logic              o_rready
);

  master_state_e r_state, w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_resp;
  logic              r_timeout;

  logic w_hs, w_wait, w_expire, w_clr, w_accept;

  // Handshake and wait decode kept outside the FSM block so the watchdog path stays acyclic.
  assign w_hs = ((r_state == WR_ADDR) && i_awready) ||
                ((r_state == WR_DATA) && i_wready)  ||
                ((r_state == WR_RESP) && i_bvalid)  ||
                ((r_state == RD_ADDR) && i_arready) ||
                ((r_state == RD_DATA) && i_rvalid);

  assign w_wait   = r_state inside {WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA};
  assign w_clr    = (w_state_next != r_state);
  assign w_accept = (r_state == IDLE) && i_cmd_valid;

  axi_lite_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .aclk     (aclk),
    .arst     (arst),
    .i_clr    (w_clr),
    .i_en     (w_wait && !w_hs),
    .o_expire (w_expire)
  );

  always_ff @(posedge aclk) begin
    if (!arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_cmd_ready  = 1'b0;
    o_awvalid    = 1'b0;
    o_wvalid     = 1'b0;
    o_bready     = 1'b0;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_rsp_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_state_next = i_cmd_write ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        o_awvalid = 1'b1;
        if (i_awready)     w_state_next = WR_DATA;
        else if (w_expire) w_state_next = RESP;
      end
      WR_DATA: begin
        o_wvalid = 1'b1;
        if (i_wready)      w_state_next = WR_RESP;
        else if (w_expire) w_state_next = RESP;
      end
      WR_RESP: begin
        o_bready = 1'b1;
        if (i_bvalid)      w_state_next = RESP;
        else if (w_expire) w_state_next = RESP;
      end
      RD_ADDR: begin
        o_arvalid = 1'b1;
        if (i_arready)     w_state_next = RD_DATA;
        else if (w_expire) w_state_next = RESP;
      end
      RD_DATA: begin
        o_rready = 1'b1;
        if (i_rvalid)      w_state_next = RESP;
        else if (w_expire) w_state_next = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Response fields are cleared at command accept, so writes and timeouts report zero read data.
  always_ff @(posedge aclk) begin
    if (!arst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= OKAY;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_write   <= i_cmd_write;
        r_rdata   <= '0;
        r_resp    <= OKAY;
        r_timeout <= 1'b0;
      end
      if ((r_state == WR_RESP) && i_bvalid) begin
        r_resp <= i_bresp;
      end
      if ((r_state == RD_DATA) && i_rvalid) begin
        r_rdata <= i_rdata;
        r_resp  <= i_rresp;
      end
      if (w_expire) begin
        r_rdata   <= '0;
        r_resp    <= SLVERR;
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_awaddr      = r_addr;
  assign o_araddr      = r_addr;
  assign o_wdata       = r_wdata;
  assign o_rsp_write   = r_write;
  assign o_rsp_rdata   = r_rdata;
  assign o_rsp_resp    = r_resp;
  assign o_rsp_timeout = r_timeout;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small behavioural AXI-Lite
// memory slave (256 locations, addresses >= 256 answer DECERR).
module tb_axi_lite_master;

  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        awvalid, awready, wvalid, wready, bready, arvalid, arready, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp  = 2'b00;
  logic        rvalid = 1'b0;
  logic [31:0] rdata  = '0;
  logic [1:0]  rresp  = 2'b00;

  int n_pass  = 0;
  int n_total = 0;

  always #5 aclk = ~aclk;

  axi_lite_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .aclk          (aclk),
    .arst          (arst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_write   (cmd_write),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_write   (rsp_write),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_resp    (rsp_resp),
    .o_rsp_timeout (rsp_timeout),
    .o_awvalid     (awvalid),
    .o_awaddr      (awaddr),
    .i_awready     (awready),
    .o_wvalid      (wvalid),
    .o_wdata       (wdata),
    .i_wready      (wready),
    .i_bvalid      (bvalid),
    .i_bresp       (bresp),
    .o_bready      (bready),
    .o_arvalid     (arvalid),
    .o_araddr      (araddr),
    .i_arready     (arready),
    .i_rvalid      (rvalid),
    .i_rdata       (rdata),
    .i_rresp       (rresp),
    .o_rready      (rready)
  );

  // Behavioural slave; ar_delay/w_delay stall the ready for that many cycles.
  logic [31:0] mem [0:255];
  logic [31:0] aw_addr_q = '0;
  int ar_delay = 0;
  int w_delay  = 0;
  int ar_wait  = 0;
  int w_wait   = 0;

  assign awready = 1'b1;
  assign wready  = (w_wait >= w_delay);
  assign arready = (ar_wait >= ar_delay);

  always @(posedge aclk) begin
    if (arvalid && !arready) ar_wait <= ar_wait + 1;
    else                     ar_wait <= 0;
    if (wvalid && !wready) w_wait <= w_wait + 1;
    else                   w_wait <= 0;
    if (awvalid && awready) aw_addr_q <= awaddr;
    if (wvalid && wready) begin
      if (aw_addr_q < 32'd256) begin
        mem[aw_addr_q[7:0]] <= wdata;
        bresp <= 2'b00;
      end else begin
        bresp <= 2'b11;
      end
      bvalid <= 1'b1;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
    if (arvalid && arready) begin
      if (araddr < 32'd256) begin
        rdata <= mem[araddr[7:0]];
        rresp <= 2'b00;
      end else begin
        rdata <= '0;
        rresp <= 2'b11;
      end
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  // Counts cycles where more than one AXI channel is active at once.
  int   overlap_viol = 0;
  logic mon_en = 1'b0;
  always @(negedge aclk) begin
    if (mon_en && ($countones({awvalid, wvalid, bready, arvalid, rready}) > 1))
      overlap_viol <= overlap_viol + 1;
  end

  // Issues one command and completes its response; called and returns at a negedge.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic [1:0] resp, output logic tout,
                        output logic rwr, output int lat, output int acc_wait);
    int n;
    rd = 'x; resp = 'x; tout = 1'bx; rwr = 1'bx; lat = -1; acc_wait = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && acc_wait < 50) begin
      @(negedge aclk);
      acc_wait++;
    end
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      n_total++;
      $display("[TB] FAIL cmd_accept: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, acc_wait);
      return;
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      n_total++;
      $display("[TB] FAIL rsp_wait: rsp_valid=%b after %0d cycles, expected 1", rsp_valid, n);
      return;
    end
    lat = n; rd = rsp_rdata; resp = rsp_resp; tout = rsp_timeout; rwr = rsp_write;
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    repeat (3) @(negedge aclk);
    n_total++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b, expected 1", cmd_ready);
    else n_pass++;
    n_total++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0)
      $display("[TB] FAIL reset_valids: got %b, expected 000000",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    else n_pass++;
    n_total++;
    if ({awaddr, araddr, wdata} !== 96'h0)
      $display("[TB] FAIL reset_addr_data: got %h, expected 0", {awaddr, araddr, wdata});
    else n_pass++;
    n_total++;
    if ({rsp_rdata, rsp_resp, rsp_timeout, rsp_write} !== 36'h0)
      $display("[TB] FAIL reset_rsp: got %h, expected 0", {rsp_rdata, rsp_resp, rsp_timeout, rsp_write});
    else n_pass++;
    arst = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic [1:0] resp; logic tout, rwr; int lat, aw;
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if ({resp, tout, rwr} !== 4'b0001) $display("[TB] FAIL wr_rsp: got resp=%b tout=%b write=%b, expected 00 0 1", resp, tout, rwr);
    else n_pass++;
    n_total++;
    if (rd !== 32'h0) $display("[TB] FAIL wr_rdata: got %h, expected 0", rd);
    else n_pass++;
    n_total++;
    if (lat != 4) $display("[TB] FAIL wr_latency: got %0d, expected 4", lat);
    else n_pass++;
    do_cmd(1'b0, 32'h10, 32'h0, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if ({resp, tout, rwr} !== 4'b0000) $display("[TB] FAIL rd_rsp: got resp=%b tout=%b write=%b, expected 00 0 0", resp, tout, rwr);
    else n_pass++;
    n_total++;
    if (rd !== 32'hDEADBEEF) $display("[TB] FAIL rd_data: got %h, expected deadbeef", rd);
    else n_pass++;
    n_total++;
    if (lat != 3) $display("[TB] FAIL rd_latency: got %0d, expected 3", lat);
    else n_pass++;
  endtask

  task automatic test_decerr();
    logic [31:0] rd; logic [1:0] resp; logic tout, rwr; int lat, aw;
    do_cmd(1'b1, 32'h200, 32'h12345678, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if ({resp, tout} !== 3'b110) $display("[TB] FAIL decerr_wr: got resp=%b tout=%b, expected 11 0", resp, tout);
    else n_pass++;
    do_cmd(1'b0, 32'h300, 32'h0, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if ({resp, tout, rd} !== {2'b11, 1'b0, 32'h0}) $display("[TB] FAIL decerr_rd: got resp=%b tout=%b rdata=%h, expected 11 0 0", resp, tout, rd);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic [1:0] resp; logic tout, rwr; int lat, aw, n_ar, bad_addr;
    ar_delay = 1000;
    n_total++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL to_idle: cmd_ready got %b, expected 1", cmd_ready);
    else n_pass++;
    cmd_write = 1'b0; cmd_addr = 32'h10; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    n_ar = 0; lat = 0; bad_addr = 0;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
      if (arvalid === 1'b1) begin
        n_ar++;
        if (araddr !== 32'h10) bad_addr++;
      end
      @(negedge aclk);
    end
    n_total++;
    if (n_ar != TO) $display("[TB] FAIL to_arvalid_cycles: got %0d, expected %0d", n_ar, TO);
    else n_pass++;
    n_total++;
    if (bad_addr != 0) $display("[TB] FAIL to_araddr: %0d cycles with araddr != 10, expected 0", bad_addr);
    else n_pass++;
    n_total++;
    if (lat != TO + 1) $display("[TB] FAIL to_latency: got %0d, expected %0d", lat, TO + 1);
    else n_pass++;
    n_total++;
    if ({rsp_resp, rsp_timeout, rsp_rdata} !== {2'b10, 1'b1, 32'h0})
      $display("[TB] FAIL to_rsp: got resp=%b tout=%b rdata=%h, expected 10 1 0", rsp_resp, rsp_timeout, rsp_rdata);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    // arready arrives in the 16th cycle, the same cycle the watchdog would expire.
    ar_delay = TO - 1;
    do_cmd(1'b0, 32'h10, 32'h0, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if ({resp, tout, rd} !== {2'b00, 1'b0, 32'hDEADBEEF})
      $display("[TB] FAIL to_edge_rsp: got resp=%b tout=%b rdata=%h, expected 00 0 deadbeef", resp, tout, rd);
    else n_pass++;
    n_total++;
    if (lat != TO + 2) $display("[TB] FAIL to_edge_latency: got %0d, expected %0d", lat, TO + 2);
    else n_pass++;
    ar_delay = 0;
  endtask

  task automatic test_rsp_hold();
    logic [31:0] rd; logic [1:0] resp; logic tout, rwr; int lat, aw, n, unstable;
    do_cmd(1'b1, 32'h20, 32'h0BADF00D, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if (resp !== 2'b00) $display("[TB] FAIL hold_wr_resp: got %b, expected 00", resp);
    else n_pass++;
    cmd_write = 1'b0; cmd_addr = 32'h20; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    n_total++;
    if (n != 3) $display("[TB] FAIL hold_rd_latency: got %0d, expected 3", n);
    else n_pass++;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, cmd_ready, rsp_write, rsp_timeout, rsp_resp, rsp_rdata} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0BADF00D}) unstable++;
      @(negedge aclk);
    end
    n_total++;
    if (unstable != 0) $display("[TB] FAIL hold_stable: %0d unstable cycles, expected 0", unstable);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    n_total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) $display("[TB] FAIL hold_idle: got cmd_ready,rsp_valid=%b, expected 10", {cmd_ready, rsp_valid});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] resp; logic tout, rwr; int lat, aw, spurious;
    w_delay = 1000;
    cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h55555555; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    n_total++;
    if ({awvalid, awaddr} !== {1'b1, 32'h10}) $display("[TB] FAIL mid_aw: got awvalid=%b awaddr=%h, expected 1 10", awvalid, awaddr);
    else n_pass++;
    @(negedge aclk);
    n_total++;
    if ({wvalid, wdata} !== {1'b1, 32'h55555555}) $display("[TB] FAIL mid_w: got wvalid=%b wdata=%h, expected 1 55555555", wvalid, wdata);
    else n_pass++;
    arst = 1'b0;
    @(negedge aclk);
    arst = 1'b1;
    n_total++;
    if ({wvalid, awvalid, rsp_valid, cmd_ready} !== 4'b0001)
      $display("[TB] FAIL mid_reset: got wvalid,awvalid,rsp_valid,cmd_ready=%b, expected 0001", {wvalid, awvalid, rsp_valid, cmd_ready});
    else n_pass++;
    spurious = 0;
    repeat (3) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b0) spurious++;
    end
    n_total++;
    if (spurious != 0) $display("[TB] FAIL mid_no_rsp: %0d cycles with rsp_valid, expected 0", spurious);
    else n_pass++;
    w_delay = 0;
    do_cmd(1'b0, 32'h10, 32'h0, rd, resp, tout, rwr, lat, aw);
    n_total++;
    if ({resp, tout, rd} !== {2'b00, 1'b0, 32'hDEADBEEF})
      $display("[TB] FAIL mid_after_rd: got resp=%b tout=%b rdata=%h, expected 00 0 deadbeef", resp, tout, rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d; logic [1:0] resp; logic tout, rwr; int lat, aw, gaps;
    gaps = 0;
    overlap_viol = 0;
    mon_en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      d = {16'hC0DE, 8'h5A, 8'(a)};
      do_cmd(1'b1, 32'(a), d, rd, resp, tout, rwr, lat, aw);
      if (aw != 0) gaps++;
      n_total++;
      if ({resp, tout, lat == 4} !== 4'b0001) $display("[TB] FAIL b2b_wr%0d: got resp=%b tout=%b lat=%0d, expected 00 0 4", a, resp, tout, lat);
      else n_pass++;
      do_cmd(1'b0, 32'(a), 32'h0, rd, resp, tout, rwr, lat, aw);
      if (aw != 0) gaps++;
      n_total++;
      if ({resp, tout, rd} !== {2'b00, 1'b0, d} || lat != 3)
        $display("[TB] FAIL b2b_rd%0d: got resp=%b tout=%b rdata=%h lat=%0d, expected 00 0 %h 3", a, resp, tout, rd, lat, d);
      else n_pass++;
    end
    @(negedge aclk);
    mon_en = 1'b0;
    n_total++;
    if (gaps != 0) $display("[TB] FAIL b2b_accept_gap: %0d commands waited, expected 0", gaps);
    else n_pass++;
    n_total++;
    if (overlap_viol != 0) $display("[TB] FAIL b2b_in_flight: %0d overlapping cycles, expected 0", overlap_viol);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write_read();
    test_decerr();
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite master that sits directly upstream of the team's AXI-Lite memory slave. It accepts one read or write command at a time on a simple valid/ready command port. It sequences the AW→W→B or AR→R channel handshakes toward the slave, then returns the slave response, or a timeout error, on a valid/ready response port.

## Interface
- ADDR_W, 32, address width on cmd and AXI ports
- DATA_W, 32, data width on cmd, rsp and AXI ports
- TIMEOUT, 256, max cycles waiting on any single AXI handshake; 0 disables the watchdog
- Reset arst, synchronous, active-low; clock aclk.
- aclk  in  1  clock; all logic on rising edge
- arst  in  1  synchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address, passed unchanged
- cmd_wdata  in  DATA_W  write data
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_resp  out  2  bresp/rresp of the slave, or 2'b10 on timeout
- rsp_timeout  out  1  watchdog fired
- awvalid, awaddr / awready  out, out ADDR_W / in  AW channel
- wvalid, wdata / wready  out, out DATA_W / in  W channel
- bvalid, bresp / bready  in, in 2 / out  B channel
- arvalid, araddr / arready  out, out ADDR_W / in  AR channel
- rvalid, rdata, rresp / rready  in, in DATA_W, in 2 / out  R channel

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- cmd_ready = (state == IDLE). A command is accepted on cmd_valid && cmd_ready. Addr, data and write flag are captured into registers.
- IDLE → WR_ADDR (write) or RD_ADDR (read).
- WR_ADDR: awvalid held high until awvalid && awready; → WR_DATA.
- WR_DATA: wvalid held high until wvalid && wready; → WR_RESP. AW and W are never concurrent.
- WR_RESP: bready held high. On bvalid, bresp is captured; → RESP.
- RD_ADDR: arvalid high until arready; → RD_DATA.
- RD_DATA: rready high. On rvalid, rdata and rresp are captured; → RESP.
- RESP: rsp_valid high; rsp_* fields stable until rsp_ready; → IDLE.
- Watchdog: counter cleared on entry to each wait state and incremented each cycle without a handshake. When the count reaches TIMEOUT, the FSM:
  - drops the current valid/ready,
  - sets rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0,
  - goes to RESP.
- Slave error codes (e.g. 2'b11) are forwarded unchanged, with rsp_timeout = 0.

## Timing
- Reset values: cmd_ready 1 (state IDLE); all other outputs 0, including awaddr, araddr, wdata and rsp_*.
- Command accepted at edge T → awvalid or arvalid high in cycle T+1.
- Handshake at edge H → next channel valid/ready high in H+1. Handshake at B or R edge → rsp_valid high in the next cycle.
- Minimum write latency is 4 cycles from cmd accept to rsp_valid, when the slave is ready; read latency is 3 cycles.
- A handshake in the same cycle as watchdog expiry counts as a handshake; no timeout is reported.
- A response accepted in cycle X allows a new cmd_valid to be accepted at X+1 (one bubble cycle in IDLE).
- Reset mid-transaction: at the next edge, all AXI valid/ready go to 0, the FSM returns to IDLE, and no response is issued.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Structure
- Package axi_lite_pkg holds:
  - resp codes OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11,
  - the state enum for this block,
  - the default TIMEOUT value.
- Sub-module axi_lite_wdog: a clear/enable/expire counter, parameterised by TIMEOUT, instantiated once.
- Total RTL is 180–250 lines.

## Test plan
- Write 0x10 ← 0xDEADBEEF, then read 0x10 → two responses, both rsp_resp 00; read gives rsp_rdata 0xDEADBEEF.
- Write to 0x200 (out of slave range) → rsp_resp 2'b11, rsp_timeout 0.
- TIMEOUT = 16, slave arready tied 0 → arvalid falls after 16 cycles; rsp_resp 2'b10, rsp_timeout 1, rsp_rdata 0.
- rsp_ready held low for 5 cycles → rsp_* stable and cmd_ready 0 throughout; IDLE is re-entered on the cycle after rsp_ready.
- arst pulsed low while in WR_DATA → wvalid 0 next cycle, no rsp_valid, cmd_ready 1; the following read completes normally.
- 8 back-to-back alternating write/read commands to addresses 0–7 → all responses OKAY, read data matches, exactly one AXI transaction in flight at all times.
